// File: rtl/store_data_if.sv
// Bundle for the store buffer: MEM-stage store inputs, pipeline status and the memory write port.
interface store_data_if;
  logic [7:0]  alucontrolM;
  logic        storevalidM;
  logic [31:0] dataadrM;
  logic [31:0] writedataM;
  logic        stallM;
  logic        adesM;
  logic [31:0] badvaddrM;
  logic        empty;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic        mem_ack;

  modport slave (
    input  alucontrolM, storevalidM, dataadrM, writedataM, mem_ack,
    output stallM, adesM, badvaddrM, empty, mem_req, mem_addr, mem_wen, mem_wdata
  );

  modport master (
    output alucontrolM, storevalidM, dataadrM, writedataM, mem_ack,
    input  stallM, adesM, badvaddrM, empty, mem_req, mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/store_data.sv
// Two-entry store buffer: decodes SW/SH/SB, flags misaligned stores, queues aligned
// writes and presents the oldest one to memory until it is acknowledged.
module store_data #(
  parameter logic [7:0] EXE_SB_OP = 8'hE8,
  parameter logic [7:0] EXE_SH_OP = 8'hE9,
  parameter logic [7:0] EXE_SW_OP = 8'hEB
) (
  input  logic        clk,
  input  logic        rst,
  store_data_if.slave bus
);

  logic [1:0]  count;
  logic        rdptr;
  logic        wrptr;
  logic [29:0] addr_q  [2];
  logic [3:0]  wen_q   [2];
  logic [31:0] wdata_q [2];

  logic        is_store;
  logic        aligned;
  logic [3:0]  wen_new;
  logic [31:0] wdata_new;
  logic        enq;
  logic        deq;
  logic        full;

  assign full = (count == 2'd2);

  always_comb begin
    is_store  = 1'b0;
    aligned   = 1'b0;
    wen_new   = '0;
    wdata_new = '0;
    if (bus.storevalidM) begin
      if (bus.alucontrolM == EXE_SW_OP) begin
        is_store  = 1'b1;
        aligned   = (bus.dataadrM[1:0] == 2'b00);
        wen_new   = 4'b1111;
        wdata_new = bus.writedataM;
      end else if (bus.alucontrolM == EXE_SH_OP) begin
        is_store  = 1'b1;
        aligned   = ~bus.dataadrM[0];
        wen_new   = bus.dataadrM[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{bus.writedataM[15:0]}};
      end else if (bus.alucontrolM == EXE_SB_OP) begin
        is_store  = 1'b1;
        aligned   = 1'b1;
        wen_new   = 4'b0001 << bus.dataadrM[1:0];
        wdata_new = {4{bus.writedataM[7:0]}};
      end
    end
  end

  // A full buffer never enqueues even if the head leaves this cycle; stall depends only on count.
  assign enq = is_store & aligned & ~full;
  assign deq = (count != 2'd0) & bus.mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      rdptr <= 1'b0;
      wrptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        addr_q[i]  <= '0;
        wen_q[i]   <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        addr_q[wrptr]  <= bus.dataadrM[31:2];
        wen_q[wrptr]   <= wen_new;
        wdata_q[wrptr] <= wdata_new;
        wrptr          <= ~wrptr;
      end
      if (deq) begin
        rdptr <= ~rdptr;
      end
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    bus.adesM     = is_store & ~aligned;
    bus.badvaddrM = (is_store & ~aligned) ? bus.dataadrM : '0;
    bus.stallM    = is_store & aligned & full;
    bus.empty     = (count == 2'd0);
    bus.mem_req   = (count != 2'd0);
    bus.mem_addr  = '0;
    bus.mem_wen   = '0;
    bus.mem_wdata = '0;
    if (count != 2'd0) begin
      bus.mem_addr  = {addr_q[rdptr], 2'b00};
      bus.mem_wen   = wen_q[rdptr];
      bus.mem_wdata = wdata_q[rdptr];
    end
  end

endmodule

// File: doc/store_data.md
STORE_DATA -- requirements
Module: store_data

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 alucontrolM  input  8  MEM-stage operation code; `EXE_SW_OP`, `EXE_SH_OP` and `EXE_SB_OP` are stores, every other code is a non-store.
REQ-005 storevalidM  input  1  qualifies alucontrolM, dataadrM and writedataM this cycle.
REQ-006 dataadrM  input  32  byte address of the store.
REQ-007 writedataM  input  32  unaligned source register value.
REQ-008 stallM  output  1  store presented but not accepted this cycle; the pipeline holds MEM inputs stable.
REQ-009 adesM  output  1  address-error-on-store exception.
REQ-010 badvaddrM  output  32  faulting address, valid while adesM=1.
REQ-011 empty  output  1  buffer holds no pending store; loads issue only while empty=1.
REQ-012 mem_req  output  1  memory write request.
REQ-013 mem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-014 mem_wen  output  4  byte write enables, bit i = byte lane i.
REQ-015 mem_wdata  output  32  lane-replicated write data.
REQ-016 mem_ack  input  1  memory accepted the write this cycle; meaningful only while mem_req=1.

Function
REQ-017 The block SHALL decode a store as storevalidM=1 with alucontrolM equal to one of the three store codes.
REQ-018 An SW store SHALL be aligned iff dataadrM[1:0]==00, and SHALL produce wen=1111 and wdata=writedataM.
REQ-019 An SH store SHALL be aligned iff dataadrM[0]==0, and SHALL produce wdata={2{writedataM[15:0]}}; wen=0011 when addr[1]=0, else 1100.
REQ-020 An SB store SHALL always be aligned, and SHALL produce wen=0001<<dataadrM[1:0] and wdata={4{writedataM[7:0]}}.
REQ-021 For a misaligned store, the block SHALL assert adesM=1 combinationally, drive badvaddrM=dataadrM, never enqueue the store, and keep stallM=0.
REQ-022 When adesM=0, badvaddrM SHALL be 0.
REQ-023 Storage SHALL be a 2-entry FIFO of {addr[31:2], wen, wdata}, with a 2-bit count (0..2) and 1-bit rd/wr pointers that wrap 1->0.
REQ-024 An aligned store SHALL enqueue at the clock edge iff count<2.
REQ-025 stallM SHALL equal (aligned store) & (count==2), derived from registered count only, with no combinational dependence on mem_ack.
REQ-026 mem_req SHALL equal (count!=0).
REQ-027 mem_addr, mem_wen and mem_wdata SHALL present the head entry while mem_req=1, and SHALL be 0 while mem_req=0.
REQ-028 The head entry SHALL dequeue at the edge where mem_req & mem_ack.
REQ-029 Request outputs SHALL hold stable while mem_req=1 & mem_ack=0, for any number of cycles.
REQ-030 When enqueue and dequeue occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-031 At count==2 with mem_ack=1, the block SHALL dequeue, SHALL NOT enqueue, and SHALL keep stallM=1 that cycle; the store is accepted the next cycle.
REQ-032 mem_ack while mem_req=0 SHALL be ignored.
REQ-033 Non-store or storevalidM=0 cycles SHALL have no effect on the FIFO and SHALL drive adesM=stallM=0.
REQ-034 Latency SHALL be: a store enqueued into an empty buffer at edge N drives mem_req=1 from cycle N+1.
REQ-035 Writes SHALL leave in program order.
REQ-036 empty SHALL equal (count==0).

Reset
REQ-037 While rst=1, count and pointers SHALL be 0, entry storage SHALL be cleared to 0, and mem_req=0, mem_wen=0, mem_addr=0, mem_wdata=0, empty=1, and stallM=0.
REQ-038 Reset asserted mid-request SHALL drop mem_req immediately (asynchronously) and discard all pending entries; no partial write is retried after reset.
REQ-039 The first enqueue after reset release SHALL be accepted on the first rising edge with rst=0.

Verification
REQ-040 Scenario: SB, addr=0x1003, wd=0x000000A5, mem_ack=1 -> next cycle mem_req=1, mem_addr=0x1000, mem_wen=1000, mem_wdata=0xA5A5A5A5; count returns to 0 one cycle later.
REQ-041 Scenario: SH, addr=0x2001 -> adesM=1, badvaddrM=0x2001, stallM=0, empty stays 1, no mem_req.
REQ-042 Scenario: three back-to-back SW (0x10, 0x14, 0x18) with mem_ack=0 -> first two enqueue, third sees stallM=1; raising mem_ack for one cycle frees a slot, and the third is accepted the following cycle; writes complete in order 0x10, 0x14, 0x18.
REQ-043 Scenario: count=1 with SH addr=0x4002, wd=0x1234BEEF and mem_ack=1 in the same cycle -> count stays 1, and the new head has wen=1100, wdata=0xBEEFBEEF.
REQ-044 Scenario: mem_ack held 0 for 5 cycles with one pending SW -> mem_addr, mem_wen and mem_wdata remain constant every cycle.
REQ-045 Scenario: rst pulsed while count=2 and mem_req=1 -> mem_req=0 and empty=1 immediately, and no write occurs after release.
